// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, size codes and op-field positions for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, CORE_RD, EXT_RD} state_t;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam int OP_UNS_BIT = 2;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-enable/data steering and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [1:0]  w_sz;
    logic        w_uns;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    always_comb begin
        w_sz    = i_op[1:0];
        w_uns   = i_op[OP_UNS_BIT];
        o_be    = w_sz == SZ_B ? 4'b0001 << i_off : w_sz == SZ_H ? 4'b0011 << {i_off[1], 1'b0} : 4'hF;
        o_wdata = w_sz == SZ_B ? {4{i_wdata[7:0]}} : w_sz == SZ_H ? {2{i_wdata[15:0]}} : i_wdata;
        w_byte  = i_off == 2'd0 ? i_rdata[7:0] : i_off == 2'd1 ? i_rdata[15:8] :
                  i_off == 2'd2 ? i_rdata[23:16] : i_rdata[31:24];
        w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        // size code 3 falls through to the full word
        o_rdata = w_sz == SZ_B ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                  w_sz == SZ_H ? {{16{~w_uns & w_half[15]}}, w_half} : i_rdata;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core MEM stage and an external master.
// Define DMEM_ARB_RR_EN for round-robin on contention instead of core priority with starvation override.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int EXT_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        core_mem_en,
    input  logic        core_wr,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_op,
    output logic [31:0] core_rdata,
    output logic        memacc_stall,
    input  logic        ext_req,
    input  logic        ext_wr,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_be,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready
);
    state_t      r_state;
    state_t      w_next;
    logic        r_wait;
    logic        r_wait_ext;
    logic        w_core_elig;
    logic        w_prio_ext;
    logic        w_sel_ext;
    logic        w_en;
    logic        w_we;
    logic        w_acc;
    logic        w_gnt;
    logic        w_core_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld;
    logic        w_unused;

    dmem_lane_align u_align (
        .i_op    (core_op),
        .i_off   (core_addr[1:0]),
        .i_wdata (core_wdata),
        .i_rdata (ram_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_ld)
    );

`ifdef DMEM_ARB_RR_EN
    logic r_last_ext;
    assign w_prio_ext = ~r_last_ext;
    assign w_unused   = ^{ext_addr[1:0], EXT_MAX_WAIT != 0};
    always_ff @(posedge clk) begin
        if (!cpurst_n) r_last_ext <= 1'b0;
        else if (w_acc) r_last_ext <= w_sel_ext;
    end
`else
    logic [7:0] r_starve;
    assign w_prio_ext = r_starve == 8'(EXT_MAX_WAIT);
    assign w_unused   = ^ext_addr[1:0];
    always_ff @(posedge clk) begin
        if (!cpurst_n || !ext_req || w_gnt) r_starve <= 8'd0;
        else if (r_starve != 8'hFF) r_starve <= r_starve + 8'd1;
    end
`endif

    // a stalled access keeps its requester until the RAM takes it
    always_comb begin
        w_core_elig = core_mem_en && r_state != CORE_RD;
        w_sel_ext   = r_wait ? r_wait_ext : ext_req && (!w_core_elig || w_prio_ext);
        w_en        = r_wait || w_core_elig || ext_req;
        w_we        = w_sel_ext ? ext_wr : core_wr;
        w_acc       = w_en && ram_ready;
        w_gnt       = w_acc && w_sel_ext;
        w_next      = w_acc && !w_we ? (w_sel_ext ? EXT_RD : CORE_RD) : IDLE;
        w_core_done = r_state == CORE_RD || (w_acc && !w_sel_ext && core_wr);
    end

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            r_state    <= IDLE;
            r_wait     <= 1'b0;
            r_wait_ext <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait     <= w_en && !ram_ready;
            r_wait_ext <= w_sel_ext;
        end
    end

    assign ram_en       = cpurst_n && w_en;
    assign ram_we       = cpurst_n && w_we;
    assign ram_be       = !cpurst_n ? 4'h0 : w_sel_ext ? ext_be : w_be;
    assign ram_addr     = !cpurst_n ? 30'd0 : w_sel_ext ? ext_addr[31:2] : core_addr[31:2];
    assign ram_wdata    = !cpurst_n ? 32'd0 : w_sel_ext ? ext_wdata : w_wdata;
    assign ext_gnt      = cpurst_n && w_gnt;
    assign ext_rvalid   = cpurst_n && r_state == EXT_RD;
    assign ext_rdata    = ext_rvalid ? ram_rdata : 32'd0;
    assign core_rdata   = cpurst_n && r_state == CORE_RD ? w_ld : 32'd0;
    assign memacc_stall = cpurst_n && core_mem_en && !w_core_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a small byte-enabled RAM model behind the arbiter.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;
    logic        clk = 1'b0;
    logic        cpurst_n;
    logic        core_mem_en, core_wr;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_op;
    logic        memacc_stall;
    logic        ext_req, ext_wr, ext_gnt, ext_rvalid;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic [3:0]  ext_be;
    logic        ram_en, ram_we, ram_ready;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] mem [0:255];
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    dmem_arbiter #(.EXT_MAX_WAIT(8)) dut (
        .clk(clk), .cpurst_n(cpurst_n),
        .core_mem_en(core_mem_en), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_op(core_op), .core_rdata(core_rdata),
        .memacc_stall(memacc_stall),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en && ram_ready) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[64] = 32'hDEADBEEF;
        ram_rdata = 32'd0;
        cpurst_n = 1'b0;
        ram_ready = 1'b1;
        core_mem_en = 1'b1; core_wr = 1'b0; core_addr = 32'h100; core_wdata = 32'd0; core_op = 3'b010;
        ext_req = 1'b0; ext_wr = 1'b0; ext_addr = 32'd0; ext_wdata = 32'd0; ext_be = 4'hF;
        @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_stall", memacc_stall, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(posedge clk);
        nxt();
        cpurst_n = 1'b1;
        @(negedge clk);
        chk("lw_en", ram_en, 1);
        chk("lw_addr", ram_addr, 32'h40);
        chk("lw_stall0", memacc_stall, 1);
        nxt();
        @(negedge clk);
        chk("lw_rdata", core_rdata, 32'hDEADBEEF);
        chk("lw_stall1", memacc_stall, 0);
        chk("lw_idle_en", ram_en, 0);
        nxt();
        core_wr = 1'b1; core_op = 3'b000; core_addr = 32'h103; core_wdata = 32'h000000A5;
        @(negedge clk);
        chk("sb_be", ram_be, 4'b1000);
        chk("sb_wdata", ram_wdata, 32'hA5A5A5A5);
        chk("sb_we", ram_we, 1);
        chk("sb_stall", memacc_stall, 0);
        nxt();
        core_wr = 1'b0;
        @(negedge clk);
        chk("lb_stall", memacc_stall, 1);
        nxt();
        @(negedge clk);
        chk("lb_rdata", core_rdata, 32'hFFFFFFA5);
        nxt();
        core_op = 3'b100;
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("lbu_rdata", core_rdata, 32'h000000A5);
        nxt();
        core_op = 3'b001; core_addr = 32'h102;
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("lh_rdata", core_rdata, 32'hFFFFA5AD);
        nxt();
        core_op = 3'b010; core_addr = 32'h100; ram_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wait_en", ram_en, 1);
            chk("wait_addr", ram_addr, 32'h40);
            chk("wait_we", ram_we, 0);
            chk("wait_stall", memacc_stall, 1);
            nxt();
        end
        ram_ready = 1'b1;
        @(negedge clk);
        chk("wait_acc_stall", memacc_stall, 1);
        nxt();
        @(negedge clk);
        chk("wait_rdata", core_rdata, 32'hA5ADBEEF);
        chk("wait_done_stall", memacc_stall, 0);
        nxt();
        core_mem_en = 1'b0;
        ext_req = 1'b1; ext_wr = 1'b0; ext_addr = 32'h100;
        @(negedge clk);
        chk("ext_gnt", ext_gnt, 1);
        chk("ext_addr", ram_addr, 32'h40);
        nxt();
        ext_req = 1'b0;
        @(negedge clk);
        chk("ext_rvalid", ext_rvalid, 1);
        chk("ext_rdata", ext_rdata, 32'hA5ADBEEF);
        chk("ext_gnt_pulse", ext_gnt, 0);
        nxt();
        core_mem_en = 1'b1; core_wr = 1'b1; core_addr = 32'h104; core_wdata = 32'h11111111;
        ext_req = 1'b1;
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            logic e;
            e = k[0];
            @(negedge clk);
            chk("rr_gnt", ext_gnt, e);
            chk("rr_stall", memacc_stall, e);
            if (k == 2) chk("rr_rvalid", ext_rvalid, 1);
            nxt();
        end
`else
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("starve_refused", ext_gnt, 0);
            chk("starve_core_stall", memacc_stall, 0);
            nxt();
        end
        @(negedge clk);
        chk("starve_gnt", ext_gnt, 1);
        chk("starve_stall", memacc_stall, 1);
        chk("starve_addr", ram_addr, 32'h40);
        nxt();
        ext_req = 1'b0;
        @(negedge clk);
        chk("starve_rvalid", ext_rvalid, 1);
        chk("starve_rdata", ext_rdata, 32'hA5ADBEEF);
        chk("starve_core_done", memacc_stall, 0);
        nxt();
`endif
        core_mem_en = 1'b0; ext_req = 1'b1;
        @(negedge clk);
        chk("rst_ext_gnt_pre", ext_gnt, 1);
        nxt();
        cpurst_n = 1'b0; ext_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", ext_rvalid, 0);
        chk("rst_mid_rdata", ext_rdata, 0);
        chk("rst_mid_en", ram_en, 0);
        chk("rst_mid_core_rdata", core_rdata, 0);
        chk("rst_mid_stall", memacc_stall, 0);
        nxt();
        @(negedge clk);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        nxt();
        cpurst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", ext_rvalid, 0);
        chk("post_rst_en", ram_en, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
